// File: rtl/amp_arb_pkg.sv
// Shared types and constants for the amp_bus_arbiter slice.
package amp_arb_pkg;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned TIMEOUT_W = 16;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } arb_state_e;

endpackage

// File: rtl/amp_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, with wrap.
module amp_rr_pick
  import amp_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               any_o
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // Scan from ptr_i upward; the 2-bit candidate index wraps naturally.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    any_o = |req_i;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr_i + SEL_W'(i);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        win_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/amp_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared 32-bit resource port.
// Optional grant watchdog enabled by defining AMP_ARB_TIMEOUT_EN; without it
// err_timeout/err_id are tied low and a grant waits for res_done indefinitely.
module amp_bus_arbiter
  import amp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               res_done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               err_timeout,
  output logic [SEL_W-1:0]   err_id
);

  // Reject watchdog limits the 16-bit counter cannot represent.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("amp_bus_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] pick_win;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;

`ifdef AMP_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [SEL_W-1:0]     err_id_q, err_id_d;
`endif

  amp_rr_pick u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Next-state: arbitrate in IDLE, hold the grant until completion (or watchdog abort).
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
`ifdef AMP_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_timeout_d = 1'b0;
    err_id_d      = err_id_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_win;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          ptr_d   = pick_idx + 2'd1;
`ifdef AMP_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        // res_done takes precedence over a coincident watchdog expiry.
        if (res_done) begin
          state_d = IDLE;
          gnt_d   = '0;
          sel_d   = '0;
          busy_d  = 1'b0;
`ifdef AMP_ARB_TIMEOUT_EN
        end else if (cnt_q == TimeoutLast) begin
          state_d       = IDLE;
          gnt_d         = '0;
          sel_d         = '0;
          busy_d        = 1'b0;
          err_timeout_d = 1'b1;
          err_id_d      = sel_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; async reset drops any transaction in flight silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
`ifdef AMP_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_id_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
`ifdef AMP_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      err_id_q      <= err_id_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
`ifdef AMP_ARB_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
  assign err_id      = err_id_q;
`else
  assign err_timeout = 1'b0;
  assign err_id      = '0;
`endif

endmodule

// File: tb/tb_amp_bus_arbiter.sv
// Scoreboarded bench for amp_bus_arbiter: the stimulus process queues expected
// grants, a monitor pops and compares on every new grant (busy rising).
module tb_amp_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       res_done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       err_timeout;
  logic [1:0] err_id;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
  } grant_t;

  grant_t exp_q[$];
  logic   mon_busy_prev = 1'b0;

  always #5 clk = ~clk;

  amp_bus_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .res_done    (res_done),
    .gnt         (gnt),
    .sel         (sel),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_id      (err_id)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_grant(input logic [3:0] g, input logic [1:0] s);
    grant_t e;
    e.gnt = g;
    e.sel = s;
    exp_q.push_back(e);
  endtask

  // Monitor: each fresh grant must match the head of the expected queue.
  initial begin : monitor
    grant_t e;
    forever begin
      @(negedge clk);
      if (busy && !mon_busy_prev) begin
        if (exp_q.size() == 0) begin
          chk("grant_expected_entries", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("grant_gnt", 32'(gnt), 32'(e.gnt));
          chk("grant_sel", 32'(sel), 32'(e.sel));
        end
      end
      mon_busy_prev = busy;
    end
  end

  // Hard stop if the sequence ever stalls.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "tb_amp_bus_arbiter stalled");
  end

  initial begin : stim
    rst_n    = 1'b0;
    req      = 4'b0000;
    res_done = 1'b0;
    repeat (2) step();
    chk("rst_gnt",  32'(gnt),  32'd0);
    chk("rst_sel",  32'(sel),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err",  32'(err_timeout), 32'd0);
    chk("rst_errid", 32'(err_id), 32'd0);

    // Fairness: all request, done in every granted cycle; ptr starts at 0.
    rst_n = 1'b1;
    req   = 4'b1111;
    expect_grant(4'b0001, 2'd0);
    expect_grant(4'b0010, 2'd1);
    expect_grant(4'b0100, 2'd2);
    expect_grant(4'b1000, 2'd3);
    expect_grant(4'b0001, 2'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fair_busy", 32'(busy), 32'd1);
      res_done = 1'b1;
      if (i == 4) req = 4'b0000;
      step();
      res_done = 1'b0;
      chk("fair_release_busy", 32'(busy), 32'd0);
      chk("fair_release_gnt", 32'(gnt), 32'd0);
    end

    // Single requester (ptr = 1).
    req = 4'b0010;
    expect_grant(4'b0010, 2'd1);
    step();
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_sel", 32'(sel), 32'd1);
    req = 4'b0000;
    step();
    chk("single_hold", 32'(gnt), 32'b0010);
    step();
    res_done = 1'b1;
    step();
    res_done = 1'b0;
    chk("single_done_gnt", 32'(gnt), 32'd0);
    chk("single_done_busy", 32'(busy), 32'd0);

    // Hold: requests change mid-grant (ptr = 2, winner 3).
    req = 4'b1000;
    expect_grant(4'b1000, 2'd3);
    step();
    req = 4'b0011;
    repeat (3) begin
      step();
      chk("hold_gnt", 32'(gnt), 32'b1000);
      chk("hold_sel", 32'(sel), 32'd3);
    end
    res_done = 1'b1;
    req      = 4'b0000;
    step();
    res_done = 1'b0;
    chk("hold_done_gnt", 32'(gnt), 32'd0);

    // Stray res_done in IDLE must do nothing.
    res_done = 1'b1;
    step();
    res_done = 1'b0;
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_gnt", 32'(gnt), 32'd0);
    step();
    chk("stray_busy2", 32'(busy), 32'd0);

    // Wrap and skip: grant 2 moves ptr to 3, then 0101 -> 0001, then 0101 -> 0100.
    req = 4'b0100;
    expect_grant(4'b0100, 2'd2);
    step();
    req      = 4'b0000;
    res_done = 1'b1;
    step();
    res_done = 1'b0;
    req      = 4'b0101;
    expect_grant(4'b0001, 2'd0);
    expect_grant(4'b0100, 2'd2);
    step();
    chk("wrap_gnt", 32'(gnt), 32'b0001);
    res_done = 1'b1;
    step();
    res_done = 1'b0;
    chk("wrap_idle", 32'(busy), 32'd0);
    step();
    chk("skip_gnt", 32'(gnt), 32'b0100);
    res_done = 1'b1;
    req      = 4'b0000;
    step();
    res_done = 1'b0;

    // Reset mid-grant of 0100 (ptr = 3), then ptr restarts at 0.
    req = 4'b0100;
    expect_grant(4'b0100, 2'd2);
    step();
    req = 4'b1111;
    step();
    chk("pre_rst_gnt", 32'(gnt), 32'b0100);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_sel", 32'(sel), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    expect_grant(4'b0001, 2'd0);
    step();
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    res_done = 1'b1;
    req      = 4'b0000;
    step();
    res_done = 1'b0;

`ifdef AMP_ARB_TIMEOUT_EN
    // Watchdog abort after four granted cycles without completion.
    req = 4'b0100;
    expect_grant(4'b0100, 2'd2);
    step();
    req = 4'b0000;
    repeat (3) begin
      step();
      chk("to_busy", 32'(busy), 32'd1);
      chk("to_err_low", 32'(err_timeout), 32'd0);
    end
    step();
    chk("to_err_pulse", 32'(err_timeout), 32'd1);
    chk("to_err_id", 32'(err_id), 32'd2);
    chk("to_busy_clr", 32'(busy), 32'd0);
    chk("to_gnt_clr", 32'(gnt), 32'd0);
    step();
    chk("to_err_drop", 32'(err_timeout), 32'd0);
    chk("to_err_id_held", 32'(err_id), 32'd2);

    // Completion coinciding with the limit wins.
    req = 4'b0100;
    expect_grant(4'b0100, 2'd2);
    step();
    req = 4'b0000;
    repeat (3) step();
    res_done = 1'b1;
    step();
    res_done = 1'b0;
    chk("coinc_err", 32'(err_timeout), 32'd0);
    chk("coinc_busy", 32'(busy), 32'd0);
`else
    chk("no_to_err", 32'(err_timeout), 32'd0);
    chk("no_to_errid", 32'(err_id), 32'd0);
`endif

    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/amp_bus_arbiter.md
# amp_bus_arbiter

Round-robin arbiter and sequencer for a shared 32-bit resource port, fed through the 4-to-1 select mux in the datapath. Four requesters compete. The arbiter drives the mux select and a one-hot grant, then holds ownership until the resource signals completion. It sits between the four client units (fetch, load/store, DMA, debug) and the single memory/bus port.

## Interface
- `NUM_REQ`, default 4: number of requesters. Fixed at 4 to match the 2-bit mux select.
- `TIMEOUT_CYCLES`, default 256: watchdog limit in cycles. Used only when the timeout feature is compiled in. Legal range 2..65535.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, 4: per-requester request levels.
- `res_done`, input, 1: resource completion, a single-cycle pulse.
- `gnt`, output, 4: one-hot grant, registered.
- `sel`, output, 2: mux select, binary encoding of `gnt`, registered.
- `busy`, output, 1: transaction in progress; this is the resource valid.
- `err_timeout`, output, 1: one-cycle pulse when a grant is aborted.
- `err_id`, output, 2: index of the requester whose grant was aborted, held until the next abort.

## Operation
- States (in the shared package): `IDLE`, `GRANT`.
- `IDLE`:
  - If `req` is nonzero, pick a winner round-robin starting at pointer `ptr`.
  - Register `gnt`/`sel`, set `busy` = 1, set `ptr` = (winner + 1) mod 4, go to `GRANT`.
  - If `req` is zero, stay in `IDLE`.
- `GRANT`:
  - Hold `gnt`/`sel` unchanged whatever `req` does. A requester dropping `req` mid-transaction has no effect.
  - On `res_done` = 1: clear `gnt`, `sel` and `busy`, go to `IDLE`.
- `res_done` while in `IDLE` is ignored.
- A requester must deassert `req` by the cycle after seeing `res_done` unless it has further work. A `req` still high in the `IDLE` cycle after its `done` is treated as a new request, at lowest priority.
- Round-robin: priority order is `ptr`, `ptr`+1, … with mod-4 wrap. A sole requester wins regardless of `ptr`.
- `sel` is always the binary index of the set `gnt` bit. When `gnt` is 0, `sel` is 0.
- Reset (any time, including mid-`GRANT`):
  - State goes to `IDLE`, `ptr` = 0, `gnt` = 0, `sel` = 0, `busy` = 0, `err_timeout` = 0, `err_id` = 0, watchdog count = 0.
  - The transaction in flight is dropped with no error.

## Timing
- Request latency: `req` high in cycle N (in `IDLE`) produces `gnt`/`sel`/`busy` in cycle N+1.
- Release: `res_done` in cycle M produces `gnt` = 0 and `busy` = 0 in M+1, which is the `IDLE` arbitration cycle. The next grant is visible at M+2 at the earliest.
- Minimum transaction: one cycle in `GRANT` (`res_done` in the first granted cycle).
- Peak grant throughput is one transaction every 2 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro: `AMP_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to `GRANT` and increments each `GRANT` cycle without `res_done`.
  - If the counter reaches `TIMEOUT_CYCLES - 1` with no `res_done`, the next edge aborts the grant: go to `IDLE`, `gnt`/`busy` = 0, `err_timeout` = 1 for one cycle, `err_id` = aborted index.
  - If `res_done` and the limit coincide, `res_done` wins and no error is raised.
- Undefined: no counter; `err_timeout` and `err_id` are tied to 0; `GRANT` waits indefinitely.

## Structure
- Package `amp_arb_pkg`: `arb_state_e` (`IDLE`, `GRANT`), `NUM_REQ` = 4, `SEL_W` = 2, `TIMEOUT_W` = 16.
- Sub-module `amp_rr_pick`:
  - Combinational.
  - Inputs: 4-bit `req`, 2-bit `ptr`.
  - Outputs: one-hot winner, binary index, `any`.
- Top level holds the FSM, `ptr`, output registers and the optional watchdog.

## Test plan
- Reset mid-`GRANT` with `gnt` = 0100: assert `rst_n` = 0 → all outputs 0 immediately. After release, with `req` = 1111, the next grant is 0001 (`ptr` = 0).
- Single requester: `req` = 0010 at N → `gnt` = 0010, `sel` = 1, `busy` = 1 at N+1. `res_done` at N+3 → `gnt` = 0 at N+4.
- Fairness: `req` = 1111 held, `res_done` every granted cycle → grants 0001, 0010, 0100, 1000, 0001, each 2 cycles apart.
- Wrap and skip: `ptr` = 3, `req` = 0101 → `gnt` = 0001, then `ptr` = 1. The next arbitration with `req` = 0101 gives 0100.
- Hold: during `GRANT` of 1000, `req` changes to 0011 → `gnt` stays 1000 until `res_done`. Stray `res_done` in `IDLE` → no change.
- Timeout (`AMP_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4): grant 0100 with no `res_done` → `err_timeout` pulses at grant+4, `err_id` = 2, `busy` = 0. Coincident `res_done` on the 4th cycle → no error.
